// File: rtl/stream_demux.sv
// ============================================================================
// Module   : stream_demux
// Brief    : 1-to-2 stream demultiplexer with a 2-entry FIFO per output channel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_demux #(
  parameter int WL = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sel,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WL-1:0] in_data,
  output logic          out1_valid,
  input  logic          out1_ready,
  output logic [WL-1:0] out1_data,
  output logic          out2_valid,
  input  logic          out2_ready,
  output logic [WL-1:0] out2_data
);

  localparam logic [1:0] c_FULL = 2'd2;

  // Index 0 is channel 1 (sel=1), index 1 is channel 2 (sel=0).
  logic [WL-1:0] head_q [2];
  logic [WL-1:0] head_d [2];
  logic [WL-1:0] tail_q [2];
  logic [WL-1:0] tail_d [2];
  logic [1:0]    cnt_q  [2];
  logic [1:0]    cnt_d  [2];
  logic [1:0]    w_enq;
  logic [1:0]    w_deq;
  logic [1:0]    w_rdy;

  // Readiness looks only at registered occupancy, never at the consumer readys.
  assign in_ready = !rst && (sel ? (cnt_q[0] != c_FULL) : (cnt_q[1] != c_FULL));

  always_comb begin
    w_enq    = 2'b00;
    w_enq[0] = in_valid && in_ready && sel;
    w_enq[1] = in_valid && in_ready && !sel;
    w_rdy    = {out2_ready, out1_ready};
  end

  always_comb begin
    w_deq = 2'b00;
    for (int c = 0; c < 2; c++) begin
      head_d[c] = head_q[c];
      tail_d[c] = tail_q[c];
      cnt_d[c]  = cnt_q[c];
      w_deq[c]  = (cnt_q[c] != 2'd0) && w_rdy[c];
      case ({w_enq[c], w_deq[c]})
        2'b10: begin
          if (cnt_q[c] == 2'd0) head_d[c] = in_data;
          else                  tail_d[c] = in_data;
          cnt_d[c] = cnt_q[c] + 2'd1;
        end
        2'b01: begin
          // Draining the last word leaves the head in place so data holds.
          if (cnt_q[c] == c_FULL) head_d[c] = tail_q[c];
          cnt_d[c] = cnt_q[c] - 2'd1;
        end
        2'b11: begin
          head_d[c] = in_data;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        head_q[c] <= '0;
        tail_q[c] <= '0;
        cnt_q[c]  <= 2'd0;
      end else begin
        head_q[c] <= head_d[c];
        tail_q[c] <= tail_d[c];
        cnt_q[c]  <= cnt_d[c];
      end
    end
  end

  assign out1_valid = (cnt_q[0] != 2'd0);
  assign out2_valid = (cnt_q[1] != 2'd0);
  assign out1_data  = head_q[0];
  assign out2_data  = head_q[1];

endmodule

`default_nettype wire
